dcc_packet_encoder: RTL

//  Consumes the encoder port of the address/command memory. Scans the slots

---
 rtl/dcc_packet_encoder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dcc_packet_encoder.sv
// dcc_packet_encoder: scans slot memory and serialises valid entries as continuous DCC track packets
// Optional oneshot write-back (valid bit clear) is enabled by defining DCC_ONESHOT_CLR_EN.
module dcc_packet_encoder #(
  parameter int CLK_MHZ       = 50,
  parameter int NUM_SLOTS     = 512,
  parameter int PREAMBLE_BITS = 14,
  parameter int HALF_ONE_US   = 58,
  parameter int HALF_ZERO_US  = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [9:0]  mem_address,
  input  logic [31:0] mem_dat_in,
  output logic [31:0] mem_dat_out,
  output logic        mem_wr,
  output logic        dcc_out,
  output logic        dcc_out_n,
  output logic        pkt_done
);
  localparam int HO = HALF_ONE_US * CLK_MHZ;
  localparam int HZ = HALF_ZERO_US * CLK_MHZ;
  localparam int TW = $clog2((HO > HZ ? HO : HZ) + 1);
  localparam logic [31:0] IDLE = 32'h80FF_0000;
  typedef enum logic [2:0] {OFF, PREAMBLE, START, BYTE, SEP, END} state_t;
  state_t state, state_n;
  logic [4:0] bc, bc_n;
  logic [1:0] bi, bi_n;
  logic [TW-1:0] tcnt, hlen;
  logic half, cur_bit, bit_end, ready, sph, wb_busy, last_byte;
  logic [9:0] ptr, nprobe, pkt_slot;
  logic [31:0] pkt;
  logic [7:0] chk, cur_byte;
  assign chk = pkt[23:16] ^ pkt[15:8] ^ (pkt[30] ? pkt[7:0] : 8'h00);
  assign cur_byte = bi == 2'd0 ? pkt[23:16] : bi == 2'd1 ? pkt[15:8] :
                    (bi == 2'd2 && pkt[30]) ? pkt[7:0] : chk;
  assign last_byte = bi == (pkt[30] ? 2'd3 : 2'd2);
  assign cur_bit = state == BYTE ? cur_byte[bc[2:0]] : state inside {PREAMBLE, END};
  assign hlen = cur_bit ? TW'(HO) : TW'(HZ);
  assign bit_end = half && tcnt == hlen - TW'(1);
  assign pkt_done = state == END && bit_end;
  assign dcc_out = state != OFF && !half;
  assign dcc_out_n = state != OFF && half;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= OFF;
      bc <= 5'd0;
      bi <= 2'd0;
    end else begin
      state <= state_n;
      bc <= bc_n;
      bi <= bi_n;
    end
  always_comb begin
    state_n = state;
    bc_n = bc;
    bi_n = bi;
    case (state)
      OFF: if (en) begin
        state_n = PREAMBLE;
        bc_n = 5'd0;
      end
      // keep sending '1' bits past the minimum until the scanner has a packet
      PREAMBLE: if (bit_end) begin
        if (bc >= 5'(PREAMBLE_BITS - 1) && ready) state_n = START;
        else if (bc != 5'd31) bc_n = bc + 5'd1;
      end
      START: if (bit_end) begin
        state_n = BYTE;
        bc_n = 5'd7;
        bi_n = 2'd0;
      end
      BYTE: if (bit_end) begin
        if (bc != 5'd0) bc_n = bc - 5'd1;
        else state_n = last_byte ? END : SEP;
      end
      SEP: if (bit_end) begin
        state_n = BYTE;
        bc_n = 5'd7;
        bi_n = bi + 2'd1;
      end
      END: if (bit_end) begin
        state_n = en ? PREAMBLE : OFF;
        bc_n = 5'd0;
      end
      default: state_n = OFF;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      half <= 1'b0;
      tcnt <= '0;
    end else if (state == OFF) begin
      half <= 1'b0;
      tcnt <= '0;
    end else if (tcnt == hlen - TW'(1)) begin
      half <= ~half;
      tcnt <= '0;
    end else tcnt <= tcnt + TW'(1);
  // two cycles per probe: address presented in phase 0, data sampled at end of phase 1
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ptr <= 10'd0;
      nprobe <= 10'd0;
      sph <= 1'b0;
      ready <= 1'b0;
      pkt <= 32'd0;
      pkt_slot <= 10'd0;
    end else if (state != PREAMBLE) begin
      ready <= 1'b0;
      sph <= 1'b0;
      nprobe <= 10'd0;
    end else if (!ready && !wb_busy) begin
      sph <= ~sph;
      if (sph) begin
        ptr <= ptr == 10'(NUM_SLOTS - 1) ? 10'd0 : ptr + 10'd1;
        nprobe <= nprobe + 10'd1;
        if (mem_dat_in[31]) begin
          ready <= 1'b1;
          pkt <= mem_dat_in;
          pkt_slot <= ptr;
        end else if (nprobe == 10'(NUM_SLOTS - 1)) begin
          ready <= 1'b1;
          pkt <= IDLE;
        end
      end
    end
`ifdef DCC_ONESHOT_CLR_EN
  logic wb_pend;
  logic [1:0] wb_ph;
  logic [31:0] wb_word;
  logic [9:0] wb_addr;
  assign wb_busy = wb_pend;
  assign mem_address = wb_pend ? wb_addr : ptr;
  // clear valid only if the host has not rewritten the slot since it was latched
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wb_pend <= 1'b0;
      wb_ph <= 2'd0;
      wb_word <= 32'd0;
      wb_addr <= 10'd0;
      mem_wr <= 1'b0;
      mem_dat_out <= 32'd0;
    end else begin
      mem_wr <= 1'b0;
      if (pkt_done && pkt[29]) begin
        wb_pend <= 1'b1;
        wb_ph <= 2'd0;
        wb_word <= pkt;
        wb_addr <= pkt_slot;
      end else if (wb_pend) begin
        wb_ph <= wb_ph + 2'd1;
        if (wb_ph == 2'd1 && mem_dat_in == wb_word) begin
          mem_wr <= 1'b1;
          mem_dat_out <= {1'b0, wb_word[30:0]};
        end
        if (wb_ph == 2'd2) wb_pend <= 1'b0;
      end
    end
`else
  logic unused_bits;
  assign unused_bits = ^{pkt[29:24], pkt_slot};
  assign wb_busy = 1'b0;
  assign mem_address = ptr;
  assign mem_wr = 1'b0;
  assign mem_dat_out = 32'd0;
`endif
endmodule
